// File: rtl/morra_cinese_param.sv
// morra_cinese_param: parametrised rock-paper-scissors match referee with scores, manche count and early win by lead
module morra_cinese_param #(
    parameter int CFG_W      = 4,
    parameter int MIN_MANCHE = 4,
    parameter int LEAD       = 2,
    parameter int CNT_W      = $clog2(MIN_MANCHE + 2**CFG_W)
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic             INIZIA,
    input  logic [CFG_W-1:0] CONFIG,
    input  logic             MOSSA_VALIDA,
    input  logic [1:0]       PRIMO,
    input  logic [1:0]       SECONDO,
    output logic [1:0]       MANCHE,
    output logic             MANCHE_VLD,
    output logic [1:0]       PARTITA,
    output logic [CNT_W-1:0] PUNTI_1,
    output logic [CNT_W-1:0] PUNTI_2,
    output logic [CNT_W-1:0] N_MANCHE,
    output logic             IN_CORSO
);
    typedef enum logic [1:0] {IDLE, GIOCO, FINE} state_t;

    state_t           r_state, w_state;
    logic [1:0]       r_manche, w_manche, r_partita, w_partita, r_rm, w_rm;
    logic             r_vld, w_vld, r_corso, w_corso, r_rv, w_rv, r_rp, w_rp;
    logic [CNT_W-1:0] r_p1, w_p1, r_p2, w_p2, r_n, w_n, r_max, w_max;
    logic             w_b1, w_b2, w_draw, w_inv, w_end;
    logic [CNT_W-1:0] w_p1n, w_p2n, w_nn, w_lead;

    // judge the presented manche: who wins, and whether it breaks the repeat restriction
    always_comb begin
        w_b1   = (PRIMO == 2'b01 && SECONDO == 2'b11) || (PRIMO == 2'b11 && SECONDO == 2'b10) ||
                 (PRIMO == 2'b10 && SECONDO == 2'b01);
        w_b2   = (SECONDO == 2'b01 && PRIMO == 2'b11) || (SECONDO == 2'b11 && PRIMO == 2'b10) ||
                 (SECONDO == 2'b10 && PRIMO == 2'b01);
        w_draw = PRIMO == SECONDO;
        w_inv  = PRIMO == 2'b00 || SECONDO == 2'b00 || (r_rv && (r_rp ? SECONDO == r_rm : PRIMO == r_rm));
        w_p1n  = r_p1 + CNT_W'(w_b1);
        w_p2n  = r_p2 + CNT_W'(w_b2);
        w_nn   = r_n + CNT_W'(1);
        w_lead = w_p1n > w_p2n ? w_p1n - w_p2n : w_p2n - w_p1n;
        w_end  = (w_nn >= CNT_W'(MIN_MANCHE) && w_lead >= CNT_W'(LEAD)) || w_nn == r_max;
    end

    // next-state and next-output logic; INIZIA has priority over the move strobe
    always_comb begin
        w_state   = r_state;
        w_manche  = 2'b00;
        w_vld     = 1'b0;
        w_partita = r_partita;
        w_p1      = r_p1;
        w_p2      = r_p2;
        w_n       = r_n;
        w_max     = r_max;
        w_rv      = r_rv;
        w_rp      = r_rp;
        w_rm      = r_rm;
        if (INIZIA) begin
            w_state   = GIOCO;
            w_partita = 2'b00;
            w_p1      = '0;
            w_p2      = '0;
            w_n       = '0;
            w_max     = CNT_W'(MIN_MANCHE) + CNT_W'(CONFIG);
            w_rv      = 1'b0;
            w_rp      = 1'b0;
            w_rm      = 2'b00;
        end else if (r_state == GIOCO && MOSSA_VALIDA) begin
            w_vld = 1'b1;
            if (!w_inv) begin
                w_manche = w_draw ? 2'b11 : w_b1 ? 2'b01 : 2'b10;
                w_p1     = w_p1n;
                w_p2     = w_p2n;
                w_n      = w_nn;
                w_rv     = !w_draw;
                w_rp     = w_b2;
                w_rm     = w_b1 ? PRIMO : SECONDO;
                if (w_end) begin
                    w_state   = FINE;
                    w_partita = w_p1n > w_p2n ? 2'b01 : w_p2n > w_p1n ? 2'b10 : 2'b11;
                end
            end
        end
        w_corso = w_state == GIOCO;
    end

    // state and registered outputs
    always_ff @(posedge clk) begin
        if (RESET) begin
            r_state   <= IDLE;
            r_manche  <= 2'b00;
            r_vld     <= 1'b0;
            r_partita <= 2'b00;
            r_corso   <= 1'b0;
            r_p1      <= '0;
            r_p2      <= '0;
            r_n       <= '0;
            r_max     <= CNT_W'(MIN_MANCHE);
            r_rv      <= 1'b0;
            r_rp      <= 1'b0;
            r_rm      <= 2'b00;
        end else begin
            r_state   <= w_state;
            r_manche  <= w_manche;
            r_vld     <= w_vld;
            r_partita <= w_partita;
            r_corso   <= w_corso;
            r_p1      <= w_p1;
            r_p2      <= w_p2;
            r_n       <= w_n;
            r_max     <= w_max;
            r_rv      <= w_rv;
            r_rp      <= w_rp;
            r_rm      <= w_rm;
        end
    end

    assign MANCHE     = r_manche;
    assign MANCHE_VLD = r_vld;
    assign PARTITA    = r_partita;
    assign PUNTI_1    = r_p1;
    assign PUNTI_2    = r_p2;
    assign N_MANCHE   = r_n;
    assign IN_CORSO   = r_corso;
endmodule
